// File: rtl/switch_in_port.sv
// Synchronizes and debounces two slide-switch groups into stable input-port values with a sticky change flag.
// Define SWITCH_IN_PORT_LATCH_EN to load the ports only on a debounced key press (key_raw, active-low).
module switch_in_port #(
    parameter int unsigned WIDTH           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             mem_clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] sw_raw0,
    input  logic [WIDTH-1:0] sw_raw1,
    input  logic             key_raw,
    input  logic             ack,
    output logic [WIDTH-1:0] in_port0,
    output logic [WIDTH-1:0] in_port1,
    output logic             changed
);

    localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0][WIDTH-1:0] sw_s1;
    logic [1:0][WIDTH-1:0] sw_s2;
    logic [1:0][WIDTH-1:0] sw_last;
    logic [1:0][WIDTH-1:0] sw_stable;
    logic [1:0][WIDTH-1:0] sw_stable_nxt;
    logic [1:0][CNT_W-1:0] sw_cnt;
    logic [1:0][CNT_W-1:0] sw_cnt_nxt;
    logic                  set_evt;
    logic                  changed_nxt;

    // Whole-vector debounce: any sample disagreeing with the previous one restarts the count
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sw_stable_nxt[i] = sw_stable[i];
            sw_cnt_nxt[i]    = sw_cnt[i];
            if ((sw_s2[i] == sw_stable[i]) || (sw_s2[i] != sw_last[i])) begin
                sw_cnt_nxt[i] = '0;
            end else if (sw_cnt[i] == CNT_LAST) begin
                sw_stable_nxt[i] = sw_s2[i];
                sw_cnt_nxt[i]    = '0;
            end else begin
                sw_cnt_nxt[i] = sw_cnt[i] + CNT_W'(1);
            end
        end
    end

    // A set event on the same edge as ack keeps the flag high
    always_comb begin
        changed_nxt = changed;
        if (set_evt) begin
            changed_nxt = 1'b1;
        end else if (ack) begin
            changed_nxt = 1'b0;
        end
    end

    always_ff @(posedge mem_clk or negedge resetn) begin
        if (!resetn) begin
            sw_s1     <= '0;
            sw_s2     <= '0;
            sw_last   <= '0;
            sw_stable <= '0;
            sw_cnt    <= '0;
            changed   <= 1'b0;
        end else begin
            sw_s1     <= {sw_raw1, sw_raw0};
            sw_s2     <= sw_s1;
            sw_last   <= sw_s2;
            sw_stable <= sw_stable_nxt;
            sw_cnt    <= sw_cnt_nxt;
            changed   <= changed_nxt;
        end
    end

`ifdef SWITCH_IN_PORT_LATCH_EN
    logic             key_s1;
    logic             key_s2;
    logic             key_last;
    logic             key_stable;
    logic             key_stable_nxt;
    logic             key_press;
    logic [CNT_W-1:0] key_cnt;
    logic [CNT_W-1:0] key_cnt_nxt;
    logic [WIDTH-1:0] port0_q;
    logic [WIDTH-1:0] port1_q;
    logic [WIDTH-1:0] port0_nxt;
    logic [WIDTH-1:0] port1_nxt;

    // Key debounce plus port load on a debounced press (stable key going 1 -> 0)
    always_comb begin
        key_stable_nxt = key_stable;
        key_cnt_nxt    = key_cnt;
        key_press      = 1'b0;
        port0_nxt      = port0_q;
        port1_nxt      = port1_q;
        set_evt        = 1'b0;
        if ((key_s2 == key_stable) || (key_s2 != key_last)) begin
            key_cnt_nxt = '0;
        end else if (key_cnt == CNT_LAST) begin
            key_stable_nxt = key_s2;
            key_cnt_nxt    = '0;
            key_press      = !key_s2;
        end else begin
            key_cnt_nxt = key_cnt + CNT_W'(1);
        end
        if (key_press) begin
            port0_nxt = sw_stable[0];
            port1_nxt = sw_stable[1];
            set_evt   = (sw_stable[0] != port0_q) || (sw_stable[1] != port1_q);
        end
    end

    always_ff @(posedge mem_clk or negedge resetn) begin
        if (!resetn) begin
            key_s1     <= 1'b1;
            key_s2     <= 1'b1;
            key_last   <= 1'b1;
            key_stable <= 1'b1;
            key_cnt    <= '0;
            port0_q    <= '0;
            port1_q    <= '0;
        end else begin
            key_s1     <= key_raw;
            key_s2     <= key_s1;
            key_last   <= key_s2;
            key_stable <= key_stable_nxt;
            key_cnt    <= key_cnt_nxt;
            port0_q    <= port0_nxt;
            port1_q    <= port1_nxt;
        end
    end

    assign in_port0 = port0_q;
    assign in_port1 = port1_q;
`else
    logic unused_key;
    assign unused_key = key_raw;

    // Ports follow the debounced registers directly
    assign set_evt  = (sw_stable_nxt != sw_stable);
    assign in_port0 = sw_stable[0];
    assign in_port1 = sw_stable[1];
`endif

endmodule

// File: tb/tb_switch_in_port.sv
// Self-checking bench for switch_in_port: directed scenarios plus random stimulus against a run-length model.
`timescale 1ns/1ps
module tb_switch_in_port;

    localparam int unsigned W  = 5;
    localparam int unsigned DC = 4;

    logic         mem_clk = 1'b0;
    logic         resetn;
    logic [W-1:0] sw_raw0;
    logic [W-1:0] sw_raw1;
    logic         key_raw;
    logic         ack;
    logic [W-1:0] in_port0;
    logic [W-1:0] in_port1;
    logic         changed;

    int n_checks = 0;
    int n_fail   = 0;

    switch_in_port #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .mem_clk  (mem_clk),
        .resetn   (resetn),
        .sw_raw0  (sw_raw0),
        .sw_raw1  (sw_raw1),
        .key_raw  (key_raw),
        .ack      (ack),
        .in_port0 (in_port0),
        .in_port1 (in_port1),
        .changed  (changed)
    );

    always #5 mem_clk = ~mem_clk;

    // Reference: a value is accepted once DC+1 consecutive synchronized samples agree and differ from the held value
    typedef struct packed {
        logic [2:0][W-1:0] p1;
        logic [2:0][W-1:0] p2;
        logic [2:0][W-1:0] rv;
        logic [2:0][W-1:0] held;
        logic [2:0][15:0]  run;
        logic [W-1:0]      port0;
        logic [W-1:0]      port1;
        logic              changed;
    } model_t;

    model_t mdl;

    function automatic model_t model_reset();
        model_t n;
        n = '0;
        n.p1[2]   = W'(1);
        n.p2[2]   = W'(1);
        n.rv[2]   = W'(1);
        n.held[2] = W'(1);
        for (int i = 0; i < 3; i++) n.run[i] = 16'd1;
        return n;
    endfunction

    function automatic model_t model_next(model_t m, logic [W-1:0] r0, logic [W-1:0] r1,
                                          logic k, logic a);
        model_t            n;
        logic [2:0][W-1:0] raw;
        logic [W-1:0]      x;
        logic [2:0]        acc;
        logic              set;
        n      = m;
        raw[0] = r0;
        raw[1] = r1;
        raw[2] = W'(k);
        for (int i = 0; i < 3; i++) begin
            x        = m.p2[i];
            n.p2[i]  = m.p1[i];
            n.p1[i]  = raw[i];
            if (x == m.rv[i]) begin
                if (m.run[i] < 16'd1000) n.run[i] = m.run[i] + 16'd1;
            end else begin
                n.rv[i]  = x;
                n.run[i] = 16'd1;
            end
            acc[i] = (n.run[i] >= 16'(DC + 1)) && (x != m.held[i]);
            if (acc[i]) n.held[i] = x;
        end
`ifdef SWITCH_IN_PORT_LATCH_EN
        set = 1'b0;
        if (acc[2] && (n.held[2] == '0)) begin
            set     = (m.held[0] != m.port0) || (m.held[1] != m.port1);
            n.port0 = m.held[0];
            n.port1 = m.held[1];
        end
`else
        set     = acc[0] | acc[1] | (acc[2] & 1'b0);
        n.port0 = n.held[0];
        n.port1 = n.held[1];
`endif
        if (set) n.changed = 1'b1;
        else if (a) n.changed = 1'b0;
        return n;
    endfunction

    always @(posedge mem_clk or negedge resetn) begin
        if (!resetn) mdl <= model_reset();
        else         mdl <= model_next(mdl, sw_raw0, sw_raw1, key_raw, ack);
    end

    task automatic test_reset();
        logic [W-1:0] exp_p0;
        logic         exp_chg;
        resetn  = 1'b0;
        sw_raw0 = 5'h1F;
        repeat (4) @(negedge mem_clk);
        n_checks++;
        if (in_port0 !== 5'h00) begin n_fail++; $display("FAIL reset_in_port0 got %h expected 00", in_port0); end
        n_checks++;
        if (in_port1 !== 5'h00) begin n_fail++; $display("FAIL reset_in_port1 got %h expected 00", in_port1); end
        n_checks++;
        if (changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed got %b expected 0", changed); end
        resetn = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge mem_clk);
`ifdef SWITCH_IN_PORT_LATCH_EN
            exp_p0  = 5'h00;
            exp_chg = 1'b0;
`else
            exp_p0  = (e >= 7) ? 5'h1F : 5'h00;
            exp_chg = (e >= 7);
`endif
            n_checks++;
            if (in_port0 !== exp_p0) begin n_fail++; $display("FAIL reset_release edge %0d in_port0 got %h expected %h", e, in_port0, exp_p0); end
            n_checks++;
            if (changed !== exp_chg) begin n_fail++; $display("FAIL reset_release edge %0d changed got %b expected %b", e, changed, exp_chg); end
        end
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 30; c++) begin
            @(negedge mem_clk);
            n_checks++;
            if (in_port1 !== 5'h00) begin n_fail++; $display("FAIL bounce_hold cycle %0d in_port1 got %h expected 00", c, in_port1); end
            if ((c % 3) == 0) sw_raw1 = (sw_raw1 == 5'h00) ? 5'h0A : 5'h00;
        end
        @(negedge mem_clk);
        sw_raw1 = 5'h0A;
        for (int e = 1; e <= 7; e++) begin
            @(negedge mem_clk);
            n_checks++;
            if (in_port1 !== ((e == 7) ? 5'h0A : 5'h00)) begin
                n_fail++; $display("FAIL bounce_settle edge %0d in_port1 got %h expected %h", e, in_port1, (e == 7) ? 5'h0A : 5'h00);
            end
        end
    endtask

    task automatic test_ack_collision();
        @(negedge mem_clk);
        ack = 1'b1;
        @(negedge mem_clk);
        ack = 1'b0;
        n_checks++;
        if (changed !== 1'b0) begin n_fail++; $display("FAIL ack_clear changed got %b expected 0", changed); end
        sw_raw0 = 5'h11;
        for (int e = 1; e <= 7; e++) begin
            @(negedge mem_clk);
            if (e == 6) begin
                n_checks++;
                if (changed !== 1'b0) begin n_fail++; $display("FAIL ack_pre changed got %b expected 0", changed); end
                ack = 1'b1;
            end
        end
        ack = 1'b0;
        n_checks++;
        if (in_port0 !== 5'h11) begin n_fail++; $display("FAIL ack_collision in_port0 got %h expected 11", in_port0); end
        n_checks++;
        if (changed !== 1'b1) begin n_fail++; $display("FAIL ack_collision changed got %b expected 1", changed); end
        repeat (3) @(negedge mem_clk);
        ack = 1'b1;
        @(negedge mem_clk);
        ack = 1'b0;
        n_checks++;
        if (changed !== 1'b0) begin n_fail++; $display("FAIL lone_ack changed got %b expected 0", changed); end
    endtask

    task automatic test_skewed_vector();
        sw_raw0 = 5'h00;
        repeat (12) @(negedge mem_clk);
        n_checks++;
        if (in_port0 !== 5'h00) begin n_fail++; $display("FAIL skew_start in_port0 got %h expected 00", in_port0); end
        sw_raw0 = 5'h01;
        repeat (2) @(negedge mem_clk);
        sw_raw0 = 5'h03;
        for (int e = 1; e <= 10; e++) begin
            @(negedge mem_clk);
            n_checks++;
            if (in_port0 !== ((e >= 7) ? 5'h03 : 5'h00)) begin
                n_fail++; $display("FAIL skew edge %0d in_port0 got %h expected %h", e, in_port0, (e >= 7) ? 5'h03 : 5'h00);
            end
        end
    endtask

    task automatic test_mid_count_reset();
        sw_raw0 = 5'h0C;
        repeat (5) @(negedge mem_clk);
        resetn = 1'b0;
        repeat (3) @(negedge mem_clk);
        n_checks++;
        if (in_port0 !== 5'h00) begin n_fail++; $display("FAIL midreset_hold in_port0 got %h expected 00", in_port0); end
        n_checks++;
        if (changed !== 1'b0) begin n_fail++; $display("FAIL midreset_hold changed got %b expected 0", changed); end
        resetn = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(negedge mem_clk);
            n_checks++;
            if (in_port0 !== ((e == 7) ? 5'h0C : 5'h00)) begin
                n_fail++; $display("FAIL midreset_release edge %0d in_port0 got %h expected %h", e, in_port0, (e == 7) ? 5'h0C : 5'h00);
            end
        end
        n_checks++;
        if (changed !== 1'b1) begin n_fail++; $display("FAIL midreset_release changed got %b expected 1", changed); end
    endtask

`ifdef SWITCH_IN_PORT_LATCH_EN
    task automatic test_latch();
        sw_raw0 = 5'h05;
        for (int c = 0; c < 12; c++) begin
            @(negedge mem_clk);
            n_checks++;
            if (in_port0 !== 5'h00) begin n_fail++; $display("FAIL latch_idle cycle %0d in_port0 got %h expected 00", c, in_port0); end
        end
        n_checks++;
        if (changed !== 1'b0) begin n_fail++; $display("FAIL latch_idle changed got %b expected 0", changed); end
        key_raw = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge mem_clk);
            n_checks++;
            if (in_port0 !== ((e >= 7) ? 5'h05 : 5'h00)) begin
                n_fail++; $display("FAIL latch_press edge %0d in_port0 got %h expected %h", e, in_port0, (e >= 7) ? 5'h05 : 5'h00);
            end
            n_checks++;
            if (changed !== (e >= 7)) begin n_fail++; $display("FAIL latch_press edge %0d changed got %b expected %b", e, changed, (e >= 7)); end
        end
        key_raw = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge mem_clk);
            n_checks++;
            if (in_port0 !== 5'h05) begin n_fail++; $display("FAIL latch_release cycle %0d in_port0 got %h expected 05", c, in_port0); end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge mem_clk);
            n_checks++;
            if (in_port0 !== mdl.port0) begin n_fail++; $display("FAIL random cycle %0d in_port0 got %h expected %h", c, in_port0, mdl.port0); end
            n_checks++;
            if (in_port1 !== mdl.port1) begin n_fail++; $display("FAIL random cycle %0d in_port1 got %h expected %h", c, in_port1, mdl.port1); end
            n_checks++;
            if (changed !== mdl.changed) begin n_fail++; $display("FAIL random cycle %0d changed got %b expected %b", c, changed, mdl.changed); end
            if ($urandom_range(0, 7) == 0) sw_raw0 = W'($urandom);
            if ($urandom_range(0, 7) == 0) sw_raw1 = W'($urandom);
            if ($urandom_range(0, 11) == 0) key_raw = ~key_raw;
            ack = ($urandom_range(0, 9) == 0);
        end
        ack = 1'b0;
    endtask

    initial begin
        resetn  = 1'b0;
        sw_raw0 = '0;
        sw_raw1 = '0;
        key_raw = 1'b1;
        ack     = 1'b0;
        test_reset();
`ifdef SWITCH_IN_PORT_LATCH_EN
        test_latch();
`else
        test_bounce();
        test_ack_collision();
        test_skewed_vector();
        test_mid_count_reset();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
